adc_scan_ctrl: RTL and testbench
================================

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2, number of adc_clk cycles between channel select change and soc (range 0..15).
REQ-002 Parameter TIMEOUT_CYC, default 255, number of adc_clk cycles to wait for eoc before abandoning a conversion (range 1..255).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports:
- CLK_24MHz  in  1  system clock; all flops on its rising edge
- rst  in  1  asynchronous active-high reset
- run  in  1  1 = scan enabled channels continuously
- ch_en  in  8  per-channel scan enable, bit n = channel n
- adc_eoc  in  1  end-of-conversion from ADC macro
- adc_dout  in  12  conversion result from ADC macro
- rd_ch  in  3  readback channel select
- adc_clk  out  1  ADC macro clock, CLK_24MHz/2 (12 MHz)
- adc_pd  out  1  ADC power-down
- adc_s  out  3  ADC channel select
- adc_soc  out  1  ADC start-of-conversion
- res_valid  out  1  one-cycle strobe, new result stored
- res_ch  out  3  channel of current result
- res_data  out  12  current result
- err_timeout  out  1  one-cycle strobe, conversion abandoned
- busy  out  1  FSM not in IDLE
- rd_data  out  12  last stored result of channel rd_ch (combinational read of result bank)

Function
REQ-005 adc_clk SHALL be a register toggling every CLK_24MHz cycle; a "tick" is a CLK_24MHz edge on which adc_clk goes 1->0.
REQ-006 FSM state, counters, adc_s, adc_soc and adc_pd SHALL change only on ticks (falling adc_clk edges); adc_eoc and adc_dout SHALL be sampled only on ticks.
REQ-007 FSM states: IDLE, SETTLE, SOC, WAIT.
REQ-008 IDLE: adc_pd=1, adc_soc=0; on a tick with run=1 and ch_en!=0, select next channel (REQ-012), load adc_s, clear settle counter, adc_pd=0, go SETTLE.
REQ-009 SETTLE: count ticks; after SETTLE_CYC ticks (immediately at next tick if 0) assert adc_soc, go SOC.
REQ-010 SOC: adc_soc SHALL be high for exactly one adc_clk cycle; next tick deassert adc_soc, clear timeout counter, go WAIT.
REQ-011 WAIT: eoc accepted only as a sampled 0->1 transition; on acceptance capture adc_dout into result bank[adc_s], res_data, res_ch; then if run=1 and ch_en!=0 select next channel and go SETTLE, else go IDLE.
REQ-012 Channel selection: round-robin, search ascending from (last channel + 1) mod 8, skipping disabled channels, wrap 7->0; first selection after reset starts the search at channel 0; a single enabled channel is reselected every scan.
REQ-013 ch_en is evaluated only at selection time; clearing a channel's bit mid-conversion does not abort that conversion.
REQ-014 Timeout: if TIMEOUT_CYC ticks elapse in WAIT without accepted eoc, pulse err_timeout, leave result bank and res_* unchanged, advance as in REQ-011.
REQ-015 eoc rise and timeout on the same tick: eoc wins, no err_timeout.
REQ-016 res_valid and err_timeout SHALL each be high for exactly one CLK_24MHz cycle, the cycle after the deciding tick.
REQ-017 run deasserted mid-scan: current conversion completes (or times out) and is reported; then IDLE.
REQ-018 busy = 1 in every state except IDLE.

Reset
REQ-019 rst SHALL asynchronously force: state IDLE, adc_clk=0, adc_pd=1, adc_s=0, adc_soc=0, res_valid=0, err_timeout=0, res_ch=0, res_data=0, busy=0, all result bank entries 0, last channel pointer = 7 (so first selection is channel 0), all counters 0.
REQ-020 rst asserted mid-conversion SHALL abort without any res_valid or err_timeout strobe; any subsequent eoc from the macro is ignored until a new SOC.

Verification
REQ-021 run=1, ch_en=8'h41, ADC model eoc 14 adc_clk cycles after soc returning 12'h5A0 (ch0) / 12'h0F3 (ch6) -> adc_s sequence 0,6,0,6...; res_valid with (res_ch,res_data)=(0,5A0),(6,0F3); rd_ch=6 -> rd_data=12'h0F3.
REQ-022 Default params, single channel 3 -> adc_soc high exactly 2 CLK_24MHz cycles, rising 2 ticks after adc_s=3 is set; soc-to-soc spacing = SETTLE_CYC+1+eoc latency ticks.
REQ-023 ADC model never asserts eoc, TIMEOUT_CYC=255 -> err_timeout pulses 255 ticks after soc falls, no res_valid, rd_data unchanged, next channel scanned.
REQ-024 eoc held high continuously across conversions -> no second acceptance; each conversion times out after the first.
REQ-025 run dropped during WAIT -> result of that conversion still reported, then busy=0, adc_pd=1; ch_en=0 with run=1 -> stays IDLE, adc_pd=1.
REQ-026 rst pulsed during WAIT with eoc arriving 1 tick later -> all outputs at REQ-019 values, no res_valid, rd_data=0 for all channels.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan controller for an 8-channel SAR ADC macro.
// The macro runs on adc_clk = CLK_24MHz/2; all sequencing advances on falling adc_clk edges.
module adc_scan_ctrl #(
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        CLK_24MHz,
    input  logic        rst,
    input  logic        run,
    input  logic [7:0]  ch_en,
    input  logic        adc_eoc,
    input  logic [11:0] adc_dout,
    input  logic [2:0]  rd_ch,
    output logic        adc_clk,
    output logic        adc_pd,
    output logic [2:0]  adc_s,
    output logic        adc_soc,
    output logic        res_valid,
    output logic [2:0]  res_ch,
    output logic [11:0] res_data,
    output logic        err_timeout,
    output logic        busy,
    output logic [11:0] rd_data
);

    typedef enum logic [1:0] {IDLE, SETTLE, SOC, WAIT} state_t;

    state_t             state;
    logic [3:0]         settle_cnt;
    logic [7:0]         tmo_cnt;
    logic [2:0]         last_ch;
    logic               eoc_q;
    logic [7:0][11:0]   bank;
    logic [2:0]         nxt_ch;
    logic               can_go;
    logic               eoc_rise;
    logic               tmo_hit;

    // Descending offsets so the nearest enabled channel after last_ch wins;
    // offset 8 wraps to last_ch itself (single enabled channel case).
    always_comb begin
        nxt_ch = last_ch;
        for (int i = 8; i >= 1; i--) begin
            if (ch_en[last_ch + 3'(i)])
                nxt_ch = last_ch + 3'(i);
        end
    end

    assign can_go   = run && (ch_en != 8'd0);
    assign eoc_rise = adc_eoc && !eoc_q;
    assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT_CYC - 1));
    assign busy     = (state != IDLE);
    assign rd_data  = bank[rd_ch];

    always_ff @(posedge CLK_24MHz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            adc_clk     <= 1'b0;
            adc_pd      <= 1'b1;
            adc_s       <= 3'd0;
            adc_soc     <= 1'b0;
            res_valid   <= 1'b0;
            err_timeout <= 1'b0;
            res_ch      <= 3'd0;
            res_data    <= 12'd0;
            bank        <= '0;
            last_ch     <= 3'd7;
            settle_cnt  <= 4'd0;
            tmo_cnt     <= 8'd0;
            eoc_q       <= 1'b0;
        end else begin
            adc_clk     <= ~adc_clk;
            res_valid   <= 1'b0;
            err_timeout <= 1'b0;
            // adc_clk high here means it falls on this edge: a tick
            if (adc_clk) begin
                eoc_q <= adc_eoc;
                case (state)
                    IDLE: begin
                        adc_pd  <= 1'b1;
                        adc_soc <= 1'b0;
                        if (can_go) begin
                            last_ch    <= nxt_ch;
                            adc_s      <= nxt_ch;
                            settle_cnt <= 4'd0;
                            adc_pd     <= 1'b0;
                            state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (({1'b0, settle_cnt} + 5'd1) >= 5'(SETTLE_CYC)) begin
                            adc_soc <= 1'b1;
                            state   <= SOC;
                        end else begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end
                    SOC: begin
                        adc_soc <= 1'b0;
                        tmo_cnt <= 8'd0;
                        state   <= WAIT;
                    end
                    WAIT: begin
                        if (eoc_rise || tmo_hit) begin
                            // eoc wins over a timeout landing on the same tick
                            if (eoc_rise) begin
                                bank[adc_s] <= adc_dout;
                                res_data    <= adc_dout;
                                res_ch      <= adc_s;
                                res_valid   <= 1'b1;
                            end else begin
                                err_timeout <= 1'b1;
                            end
                            if (can_go) begin
                                last_ch    <= nxt_ch;
                                adc_s      <= nxt_ch;
                                settle_cnt <= 4'd0;
                                state      <= SETTLE;
                            end else begin
                                adc_pd <= 1'b1;
                                state  <= IDLE;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: ADC macro model, event-scheduled reference model
// compared every cycle, plus directed literal checks of the scan timing.
module tb_adc_scan_ctrl;

    localparam int SETTLE = 2;
    localparam int TMO    = 255;
    localparam int M_NORM = 0, M_NEVER = 1, M_STUCK = 2, M_RAND = 3;

    logic        CLK_24MHz = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  ch_en = 8'd0;
    logic        adc_eoc = 1'b0;
    logic [11:0] adc_dout = 12'd0;
    logic [2:0]  rd_ch = 3'd0;
    logic        adc_clk, adc_pd, adc_soc, res_valid, err_timeout, busy;
    logic [2:0]  adc_s, res_ch;
    logic [11:0] res_data, rd_data;

    adc_scan_ctrl #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .CLK_24MHz(CLK_24MHz), .rst(rst), .run(run), .ch_en(ch_en),
        .adc_eoc(adc_eoc), .adc_dout(adc_dout), .rd_ch(rd_ch),
        .adc_clk(adc_clk), .adc_pd(adc_pd), .adc_s(adc_s), .adc_soc(adc_soc),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
        .err_timeout(err_timeout), .busy(busy), .rd_data(rd_data)
    );

    always #5 CLK_24MHz = ~CLK_24MHz;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- ADC macro model ----------------
    int          mac_mode = M_NORM;
    int          mac_lat  = 14;
    logic [11:0] adc_val [8];
    int          conv_cnt = -1;
    int          cur_lat  = 14;
    logic [2:0]  conv_ch  = 3'd0;

    always @(negedge CLK_24MHz) begin
        if (!adc_clk) begin
            if (adc_soc) begin
                if (mac_mode != M_STUCK) adc_eoc = 1'b0;
                conv_cnt = 0;
                conv_ch  = adc_s;
                if (mac_mode == M_RAND)
                    cur_lat = ($urandom_range(0, 19) == 0) ? -5 : int'($urandom_range(1, 24));
                else
                    cur_lat = mac_lat;
            end else if (conv_cnt >= 0) begin
                conv_cnt++;
                if (conv_cnt == cur_lat) begin
                    if (mac_mode != M_NEVER) begin
                        adc_eoc  = 1'b1;
                        adc_dout = (mac_mode == M_RAND) ? 12'($urandom) : adc_val[conv_ch];
                    end
                    conv_cnt = -1;
                end
            end
        end
    end

    // ---------------- reference model (tick-scheduled) ----------------
    logic        m_clk, m_pd, m_soc, m_rv, m_err, m_busy, m_eoc_prev;
    logic [2:0]  m_s, m_rch, m_last;
    logic [11:0] m_rdata;
    logic [11:0] m_bank [8];
    int          k, soc_rise, soc_fall;

    function automatic logic [2:0] pick(input logic [2:0] last, input logic [7:0] en);
        for (int i = 1; i <= 8; i++)
            if (en[(int'(last) + i) % 8]) return 3'((int'(last) + i) % 8);
        return last;
    endfunction

    task automatic m_start();
        m_last   = pick(m_last, ch_en);
        m_s      = m_last;
        m_pd     = 1'b0;
        m_busy   = 1'b1;
        soc_rise = k + ((SETTLE == 0) ? 1 : SETTLE);
        soc_fall = soc_rise + 1;
    endtask

    always @(posedge CLK_24MHz) begin
        if (rst) begin
            m_clk = 0; m_pd = 1; m_soc = 0; m_rv = 0; m_err = 0; m_busy = 0;
            m_eoc_prev = 0; m_s = 0; m_rch = 0; m_rdata = 0; m_last = 3'd7;
            for (int i = 0; i < 8; i++) m_bank[i] = 12'd0;
            k = 0; soc_rise = 0; soc_fall = 0;
        end else begin
            logic tick, rise;
            tick  = m_clk;
            m_clk = !m_clk;
            m_rv  = 0;
            m_err = 0;
            if (tick) begin
                k++;
                rise = adc_eoc && !m_eoc_prev;
                m_eoc_prev = adc_eoc;
                if (!m_busy) begin
                    if (run && ch_en != 0) m_start();
                end else if (k == soc_rise) begin
                    m_soc = 1;
                end else if (k == soc_fall) begin
                    m_soc = 0;
                end else if (k > soc_fall && (rise || k == soc_fall + TMO)) begin
                    if (rise) begin
                        m_bank[m_s] = adc_dout; m_rch = m_s; m_rdata = adc_dout; m_rv = 1;
                    end else begin
                        m_err = 1;
                    end
                    if (run && ch_en != 0) m_start();
                    else begin m_busy = 0; m_pd = 1; end
                end
            end
        end
    end

    // ---------------- compare + monitor ----------------
    int   cyc = 0, n_res = 0, n_err = 0;
    int   soc_rise_cyc = 0, soc_fall_cyc = 0, sel_cyc = 0;
    int   soc_gap = 0, soc_w = 0, settle_d = 0, err_d = 0;
    logic prev_soc = 0, prev_busy = 0;
    logic [14:0] res_q [$];
    logic [2:0]  soc_ch [$];

    always @(posedge CLK_24MHz) begin
        #1;
        cyc++;
        if (cyc > 1)
            chk("model", {adc_clk, adc_pd, adc_s, adc_soc, res_valid, res_ch, res_data, err_timeout, busy, rd_data},
                         {m_clk, m_pd, m_s, m_soc, m_rv, m_rch, m_rdata, m_err, m_busy, m_bank[rd_ch]});
        if (adc_soc && !prev_soc) begin
            soc_gap = cyc - soc_rise_cyc; settle_d = cyc - sel_cyc;
            soc_rise_cyc = cyc; soc_ch.push_back(adc_s);
        end
        if (!adc_soc && prev_soc) begin soc_w = cyc - soc_rise_cyc; soc_fall_cyc = cyc; end
        if (err_timeout) begin err_d = cyc - soc_fall_cyc; n_err++; end
        if (res_valid) begin n_res++; res_q.push_back({res_ch, res_data}); end
        if (res_valid || err_timeout || (busy && !prev_busy)) sel_cyc = cyc;
        prev_soc = adc_soc; prev_busy = busy;
    end

    // ---------------- bounded waits ----------------
    task automatic wait_res(input int target, input int lim, input string name);
        int i = 0;
        while (n_res < target && i < lim) begin @(negedge CLK_24MHz); i++; end
        chk(name, 36'(n_res >= target), 36'd1);
    endtask

    task automatic wait_err(input int target, input int lim, input string name);
        int i = 0;
        while (n_err < target && i < lim) begin @(negedge CLK_24MHz); i++; end
        chk(name, 36'(n_err >= target), 36'd1);
    endtask

    task automatic wait_idle(input int lim, input string name);
        int i = 0;
        while (busy && i < lim) begin @(negedge CLK_24MHz); i++; end
        chk(name, 36'(busy), 36'd0);
    endtask

    task automatic wait_socfall(input int lim, input string name);
        int i = 0;
        int f0 = soc_fall_cyc;
        while (soc_fall_cyc == f0 && i < lim) begin @(negedge CLK_24MHz); i++; end
        chk(name, 36'(soc_fall_cyc != f0), 36'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, e0;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'd0;
        adc_val[0] = 12'h5A0; adc_val[6] = 12'h0F3; adc_val[3] = 12'h7C1; adc_val[1] = 12'h123;

        // reset state
        repeat (3) @(negedge CLK_24MHz);
        chk("rst_clk",  36'(adc_clk), 36'd0);
        chk("rst_pd",   36'(adc_pd), 36'd1);
        chk("rst_busy", 36'(busy), 36'd0);
        chk("rst_s",    36'(adc_s), 36'd0);
        chk("rst_data", 36'({res_ch, res_data}), 36'd0);
        rst = 1'b0;

        // run with nothing enabled stays idle
        run = 1'b1;
        repeat (20) @(negedge CLK_24MHz);
        chk("noen_busy", 36'(busy), 36'd0);
        chk("noen_pd",   36'(adc_pd), 36'd1);

        // two-channel scan 0,6,0,6
        res_q.delete(); soc_ch.delete();
        ch_en = 8'h41;
        wait_res(4, 400, "scan41_wait");
        chk("scan41_r0", 36'(res_q[0]), 36'({3'd0, 12'h5A0}));
        chk("scan41_r1", 36'(res_q[1]), 36'({3'd6, 12'h0F3}));
        chk("scan41_r2", 36'(res_q[2]), 36'({3'd0, 12'h5A0}));
        chk("scan41_s",  36'({soc_ch[0], soc_ch[1], soc_ch[2], soc_ch[3]}), 36'({3'd0, 3'd6, 3'd0, 3'd6}));
        rd_ch = 3'd6; #1;
        chk("rd_ch6", 36'(rd_data), 36'h0F3);

        // single channel 3: soc width, settle delay, spacing
        ch_en = 8'h08;
        r0 = n_res;
        wait_res(r0 + 4, 400, "ch3_wait");
        chk("ch3_res",    36'(res_q[$]), 36'({3'd3, 12'h7C1}));
        chk("ch3_socw",   36'(soc_w), 36'd2);
        chk("ch3_settle", 36'(settle_d), 36'(2 * SETTLE));
        chk("ch3_gap",    36'(soc_gap), 36'(2 * (SETTLE + 1 + 14)));

        // eoc never arrives: timeouts, bank untouched, channels still advance
        mac_mode = M_NEVER;
        ch_en = 8'h0C;
        e0 = n_err;
        wait_err(e0 + 1, 1500, "tmo_wait1");
        r0 = n_res;
        wait_err(e0 + 3, 1500, "tmo_wait3");
        chk("tmo_delay", 36'(err_d), 36'(2 * TMO));
        chk("tmo_nores", 36'(n_res), 36'(r0));
        chk("tmo_next",  36'(soc_ch[$] != soc_ch[$-1]), 36'd1);
        rd_ch = 3'd3; #1;
        chk("tmo_rd3", 36'(rd_data), 36'h7C1);
        rd_ch = 3'd2; #1;
        chk("tmo_rd2", 36'(rd_data), 36'h000);

        // eoc stuck high: one acceptance, then only timeouts
        mac_mode = M_STUCK;
        r0 = n_res; e0 = n_err;
        wait_err(e0 + 3, 2500, "stuck_wait");
        chk("stuck_one", 36'(n_res), 36'(r0 + 1));

        // run dropped during WAIT: result still reported, then idle
        mac_mode = M_NORM;
        ch_en = 8'h03;
        r0 = n_res;
        wait_res(r0 + 1, 1500, "drop_sync");
        wait_socfall(100, "drop_fall");
        repeat (4) @(negedge CLK_24MHz);
        r0 = n_res;
        run = 1'b0;
        wait_idle(100, "drop_idle");
        chk("drop_res", 36'(n_res), 36'(r0 + 1));
        chk("drop_pd",  36'(adc_pd), 36'd1);

        // randomized traffic against the model
        mac_mode = M_RAND;
        run = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK_24MHz);
            rd_ch = 3'($urandom);
            if ($urandom_range(0, 199) == 0) ch_en = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 299) == 0) run = !run;
        end
        run = 1'b0;
        wait_idle(1500, "rand_idle");
        mac_mode = M_NORM;

        // reset in the middle of WAIT, eoc arriving right after
        run = 1'b1; ch_en = 8'h10;
        wait_socfall(200, "rstw_fall");
        repeat (24) @(negedge CLK_24MHz);
        r0 = n_res; e0 = n_err;
        rst = 1'b1;
        repeat (4) @(negedge CLK_24MHz);
        chk("rstw_pd",   36'(adc_pd), 36'd1);
        chk("rstw_busy", 36'(busy), 36'd0);
        chk("rstw_out",  36'({adc_clk, adc_s, adc_soc, res_valid, err_timeout, res_ch, res_data}), 36'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK_24MHz);
            rd_ch = 3'(c); #1;
            chk("rstw_bank", 36'(rd_data), 36'd0);
        end
        @(negedge CLK_24MHz);
        rst = 1'b0;
        repeat (20) @(negedge CLK_24MHz);
        chk("rstw_nores", 36'(n_res), 36'(r0));
        chk("rstw_noerr", 36'(n_err), 36'(e0));
        run = 1'b0;
        wait_idle(200, "end_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
